button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000, meaning consecutive stable cycles needed to accept a level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, meaning cycles of held press before the first repeat pulse (500 ms).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2500000, meaning cycles between subsequent repeat pulses (100 ms).
REQ-004 SHALL have port i_Clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_Switch  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-007 SHALL have port o_Switch  output  1  debounced button level.
REQ-008 SHALL have port o_Press  output  1  single-cycle pulse on an accepted press.
REQ-009 SHALL have port o_Release  output  1  single-cycle pulse on an accepted release.
REQ-010 SHALL have port o_Repeat  output  1  single-cycle auto-repeat pulse while held.

Function
REQ-011 SHALL pass i_Switch through a two-flop synchronizer; the synchronized level lags i_Switch by 2 cycles.
REQ-012 SHALL count cycles in which the synchronized level differs from o_Switch, clearing the count on any cycle they match.
REQ-013 SHALL toggle o_Switch and clear the count on the cycle after the count reaches DEBOUNCE_LIMIT-1 while still differing.
REQ-014 SHALL assert o_Press for exactly the first cycle o_Switch is 1, and o_Release for exactly the first cycle o_Switch is 0 after a press.
REQ-015 SHALL run FSM S_IDLE -> S_HOLD on accepted press; S_HOLD -> S_REPEAT when the hold timer reaches REPEAT_DELAY-1; any state -> S_IDLE on accepted release.
REQ-016 SHALL in S_HOLD pulse o_Repeat once on the S_HOLD -> S_REPEAT transition cycle, then in S_REPEAT once every REPEAT_PERIOD cycles.
REQ-017 SHALL give release priority: no o_Repeat pulse in the same cycle as o_Release.
REQ-018 SHALL size every counter as $clog2(limit) bits and never wrap; counters saturate at their limit minus one.
REQ-019 SHALL never assert o_Press, o_Release and o_Repeat pairwise in the same cycle, except o_Press with nothing else.
REQ-020 SHALL ignore glitches shorter than DEBOUNCE_LIMIT cycles, producing no pulse and no o_Switch change.

Reset
REQ-021 SHALL on i_Rst_L low immediately force o_Switch, o_Press, o_Release, o_Repeat to 0, synchronizer flops to 0, counters to 0, FSM to S_IDLE.
REQ-022 SHALL after reset release with the button held, accept the press normally after DEBOUNCE_LIMIT stable cycles and emit o_Press.
REQ-023 SHALL on reset mid-hold or mid-repeat abandon the hold without emitting o_Release.

Configuration
REQ-024 SHALL with macro BUTTON_AUTO_REPEAT_EN defined implement S_REPEAT, the hold timer and o_Repeat per REQ-015..REQ-017.
REQ-025 SHALL without BUTTON_AUTO_REPEAT_EN omit S_REPEAT and the hold timer, tie o_Repeat to 0, and stay in S_HOLD until release.

Structure
REQ-026 SHALL place the FSM state enum (S_IDLE, S_HOLD, S_REPEAT) and default timing constants in shared package button_pkg.
REQ-027 SHALL implement the two-flop synchronizer as sub-module sync_2ff, reused for every button instance.

Verification (DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 SHALL cover clean press: i_Switch 0->1 held -> o_Switch rises 2+4 cycles later with o_Press high exactly 1 cycle.
REQ-029 SHALL cover glitch: i_Switch high 3 cycles then low -> no o_Press, o_Switch stays 0.
REQ-030 SHALL cover auto-repeat (macro on): hold 30 cycles -> o_Repeat at 10 cycles after o_Press, then every 3 cycles; none without macro.
REQ-031 SHALL cover release on a repeat boundary: release timed so the accepted release coincides with a due repeat -> o_Release only.
REQ-032 SHALL cover reset mid-repeat: drop i_Rst_L while held in S_REPEAT -> all outputs 0 at once; after release of reset, o_Press after 2+4 cycles.

Source files
------------

// File: rtl/button_pkg.sv
// ============================================================================
// Module : button_pkg
// Shared FSM state encoding, default timing constants and counter sizing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } btn_state_t;

    // Defaults assume a 25 MHz clock: 10 ms debounce, 500 ms delay, 100 ms period
    localparam int c_DEBOUNCE_LIMIT = 250000;
    localparam int c_REPEAT_DELAY   = 12500000;
    localparam int c_REPEAT_PERIOD  = 2500000;

    // A limit of 1 still needs a 1-bit counter to hold the value 0
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Two-flop synchronizer bringing one asynchronous level into the i_Clk domain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_event.sv
// ============================================================================
// Module : button_event
// Debounced push-button with press/release pulses and optional auto-repeat,
// enabled by defining BUTTON_AUTO_REPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_event #(
    parameter int DEBOUNCE_LIMIT = button_pkg::c_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = button_pkg::c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = button_pkg::c_REPEAT_PERIOD
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat
);

    import button_pkg::*;

    localparam int              c_DB_W   = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_LIMIT - 1);

    logic              w_sync;
    logic              r_switch;
    logic [c_DB_W-1:0] r_db_count;
    logic              w_differ;
    logic              w_accept;
    logic              w_accept_press;
    logic              w_accept_release;
    logic              r_press;
    logic              r_release;
    btn_state_t        r_state;
    btn_state_t        w_state_next;

    sync_2ff u_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_d     (i_Switch),
        .o_q     (w_sync)
    );

    // A new level is accepted once it has differed for DEBOUNCE_LIMIT cycles
    assign w_differ         = w_sync ^ r_switch;
    assign w_accept         = w_differ && (r_db_count == c_DB_MAX);
    assign w_accept_press   = w_accept && !r_switch;
    assign w_accept_release = w_accept &&  r_switch;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_switch   <= 1'b0;
            r_db_count <= '0;
        end else if (!w_differ) begin
            r_db_count <= '0;
        end else if (w_accept) begin
            r_switch   <= ~r_switch;
            r_db_count <= '0;
        end else begin
            r_db_count <= r_db_count + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept_press;
            r_release <= w_accept_release;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    // One timer serves both the initial delay and the repeat period
    localparam int                 c_TMR_W     = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                           REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [c_TMR_W-1:0] c_DELAY_MAX  = c_TMR_W'(REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_MAX = c_TMR_W'(REPEAT_PERIOD - 1);

    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_next;
    logic               w_repeat_next;
    logic               r_repeat;

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_repeat_next = 1'b0;
        if (w_accept_release) begin
            // Release wins over a repeat falling due in the same cycle
            w_state_next = S_IDLE;
            w_timer_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept_press) begin
                        w_state_next = S_HOLD;
                        w_timer_next = '0;
                    end
                end
                S_HOLD: begin
                    if (r_timer == c_DELAY_MAX) begin
                        w_state_next  = S_REPEAT;
                        w_timer_next  = '0;
                        w_repeat_next = 1'b1;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (r_timer == c_PERIOD_MAX) begin
                        w_timer_next  = '0;
                        w_repeat_next = 1'b1;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_timer  <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_timer  <= w_timer_next;
            r_repeat <= w_repeat_next;
        end
    end

    assign o_Repeat = r_repeat;
`else
    always_comb begin
        w_state_next = r_state;
        if (w_accept_release) begin
            w_state_next = S_IDLE;
        end else if ((r_state == S_IDLE) && w_accept_press) begin
            w_state_next = S_HOLD;
        end else if (r_state == S_REPEAT) begin
            w_state_next = S_IDLE;
        end
    end

    assign o_Repeat = 1'b0;
`endif

    assign o_Switch  = r_switch;
    assign o_Press   = r_press;
    assign o_Release = r_release;

endmodule

`default_nettype wire

// File: tb/tb_button_event.sv
// ============================================================================
// Module : tb_button_event
// Scoreboard bench for button_event with short debounce and repeat timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_event;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit c_REPEAT_EN = 1'b1;
`else
    localparam bit c_REPEAT_EN = 1'b0;
`endif

    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_REPEAT  = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic i_Clk    = 1'b0;
    logic i_Rst_L  = 1'b0;
    logic i_Switch = 1'b0;
    logic o_Switch;
    logic o_Press;
    logic o_Release;
    logic o_Repeat;

    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  t        = 0;
    ev_t sb[$];

    button_event #(
        .DEBOUNCE_LIMIT (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (i_Switch),
        .o_Switch  (o_Switch),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Repeat  (o_Repeat)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    // Press, any repeats falling strictly before the release, then the release
    task automatic expect_hold(input int press_cyc, input int rel_cyc);
        push(press_cyc, K_PRESS);
        if (c_REPEAT_EN) begin
            for (int r = press_cyc + RD; r < rel_cyc; r += RP) push(r, K_REPEAT);
        end
        push(rel_cyc, K_RELEASE);
    endtask

    // Returns 1 ns after the rising edge that brings cyc up to target
    task automatic wait_cyc(input int target);
        do begin
            @(posedge i_Clk);
            #1;
        end while (cyc < target);
    endtask

    task automatic take(input int k);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", k, 0);
        end else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge i_Clk) begin
        if (i_Rst_L) begin
            if (int'(o_Press) + int'(o_Release) + int'(o_Repeat) > 1)
                check("pulse_exclusive", int'(o_Press) + int'(o_Release) + int'(o_Repeat), 1);
            if (o_Press)   take(K_PRESS);
            if (o_Release) take(K_RELEASE);
            if (o_Repeat)  take(K_REPEAT);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_Rst_L  = 1'b0;
        i_Switch = 1'b0;
        wait_cyc(3);
        check("rst_switch",  o_Switch,  0);
        check("rst_press",   o_Press,   0);
        check("rst_release", o_Release, 0);
        check("rst_repeat",  o_Repeat,  0);
        i_Rst_L = 1'b1;

        // Clean press, short hold
        t = cyc + 2;
        wait_cyc(t);
        i_Switch = 1'b1;
        expect_hold(t + 6, t + 14);
        wait_cyc(t + 5);
        check("switch_before_accept", o_Switch, 0);
        wait_cyc(t + 6);
        check("switch_after_accept", o_Switch, 1);
        wait_cyc(t + 8);
        i_Switch = 1'b0;
        wait_cyc(t + 20);
        check("switch_released", o_Switch, 0);

        // Three-cycle glitch must be ignored
        t = cyc + 2;
        wait_cyc(t);
        i_Switch = 1'b1;
        wait_cyc(t + 3);
        i_Switch = 1'b0;
        wait_cyc(t + 6);
        check("glitch_switch_mid", o_Switch, 0);
        wait_cyc(t + 14);
        check("glitch_switch_end", o_Switch, 0);

        // Long hold for auto-repeat
        t = cyc + 2;
        wait_cyc(t);
        i_Switch = 1'b1;
        expect_hold(t + 6, t + 36);
        wait_cyc(t + 30);
        i_Switch = 1'b0;
        wait_cyc(t + 45);

        // Release accepted exactly when a repeat would be due
        t = cyc + 2;
        wait_cyc(t);
        i_Switch = 1'b1;
        expect_hold(t + 6, t + 25);
        wait_cyc(t + 19);
        i_Switch = 1'b0;
        wait_cyc(t + 25);
        check("boundary_release", o_Release, 1);
        check("boundary_no_repeat", o_Repeat, 0);
        wait_cyc(t + 35);

        // Reset while held, then re-acceptance with the button still down
        t = cyc + 2;
        wait_cyc(t);
        i_Switch = 1'b1;
        push(t + 6, K_PRESS);
        if (c_REPEAT_EN) begin
            push(t + 16, K_REPEAT);
            push(t + 19, K_REPEAT);
        end
        wait_cyc(t + 22);
        i_Rst_L = 1'b0;
        #1;
        check("midrst_switch",  o_Switch,  0);
        check("midrst_press",   o_Press,   0);
        check("midrst_release", o_Release, 0);
        check("midrst_repeat",  o_Repeat,  0);
        wait_cyc(t + 25);
        i_Rst_L = 1'b1;
        expect_hold(t + 31, t + 43);
        wait_cyc(t + 30);
        check("postrst_switch_low", o_Switch, 0);
        wait_cyc(t + 31);
        check("postrst_switch_high", o_Switch, 1);
        wait_cyc(t + 37);
        i_Switch = 1'b0;
        wait_cyc(t + 55);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
